// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : Memory-mapped UART transmitter. Bytes written by the core are
//             buffered in a circular FIFO and serialised 8N1 on tx at a bit
//             period of (div+1) clk cycles.
//  Ports    : clk, reset      - clock, asynchronous active-high reset
//             wr_en, wr_data  - byte write strobe and data
//             div             - bit period minus one (sampled at frame start)
//             clr_ovf         - clears the sticky overflow flag
//             tx              - serial output, idles high
//             busy            - frame in progress
//             full/empty/count- registered FIFO status
//             overflow        - sticky, set when a write is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic [DIV_W-1:0]              div,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    // FIFO storage and status
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_ovf;

    // Serialiser
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_tick;
    logic               w_pop;
    logic               w_shift;
    logic               w_tx_nxt;
    logic               w_push;
    logic               w_drop;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Push is judged against the registered full flag, so a pop on the same
    // edge never makes room for a write to a full FIFO.
    assign w_push = wr_en & ~r_full;
    assign w_drop = wr_en &  r_full;
    assign w_tick = (r_baud_cnt == '0);

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            // A drop on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------ FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------ FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (!r_empty) w_state_nxt = c_start;
            c_start: if (w_tick) w_state_nxt = c_data;
            c_data:  if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = c_stop;
            c_stop:  if (w_tick) w_state_nxt = r_empty ? c_idle : c_start;
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------ FSM: outputs
    // w_tx_nxt is the line level for the bit that begins after this edge;
    // registering it keeps tx glitch-free.
    always_comb begin
        w_pop    = 1'b0;
        w_shift  = 1'b0;
        w_tx_nxt = r_tx;
        case (r_state)
            c_idle: begin
                w_tx_nxt = 1'b1;
                if (!r_empty) begin
                    w_pop    = 1'b1;
                    w_tx_nxt = 1'b0;
                end
            end
            c_start: begin
                if (w_tick) w_tx_nxt = r_shift[0];
            end
            c_data: begin
                if (w_tick) begin
                    w_shift  = 1'b1;
                    // After the last data bit comes the stop bit; otherwise
                    // the bit that will sit at shift[0] after this shift.
                    w_tx_nxt = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
                end
            end
            c_stop: begin
                if (w_tick) begin
                    if (!r_empty) begin
                        w_pop    = 1'b1;
                        w_tx_nxt = 1'b0;
                    end else begin
                        w_tx_nxt = 1'b1;
                    end
                end
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------ serialiser datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_tx <= w_tx_nxt;
            if (w_pop) begin
                // Frame start: divisor is captured here and held for the frame.
                r_shift    <= r_mem[r_rd_ptr];
                r_div      <= div;
                r_baud_cnt <= div;
                r_bit_idx  <= '0;
            end else if (r_state != c_idle) begin
                if (w_tick) begin
                    r_baud_cnt <= r_div;
                    if (w_shift) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt - DIV_W'(1);
                end
            end
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != c_idle);
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Directed self-checking bench for uart_tx_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic [DIV_W-1:0] div;
    logic             clr_ovf;
    logic             tx;
    logic             busy;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .div      (div),
        .clr_ovf  (clr_ovf),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One-cycle write strobe; called and returns at a falling edge.
    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Called at the falling edge right after the pop edge; checks every cycle
    // of the 10*(d+1)-cycle frame and returns right after the frame's last edge.
    task automatic check_frame(input logic [7:0] b, input int d);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * (d + 1); i++) begin
            check("tx_bit", tx, f[i / (d + 1)]);
            if (i == 0) check("busy_frame", busy, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        div     = 16'd3;
        clr_ovf = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_tx", tx, 1);

        // Single byte, div=3: 40-cycle frame
        wr(8'h55);
        check("sb_empty", empty, 0);
        check("sb_count", count, 1);
        check("sb_tx_pre", tx, 1);
        check("sb_busy_pre", busy, 0);
        @(negedge clk);
        check_frame(8'h55, 3);
        check("sb_busy_end", busy, 0);
        check("sb_empty_end", empty, 1);
        check("sb_tx_end", tx, 1);

        // Minimum divisor
        div = 16'd0;
        wr(8'h80);
        @(negedge clk);
        check_frame(8'h80, 0);
        check("min_busy_end", busy, 0);

        // Divisor change mid-frame affects only the next frame
        div = 16'd1;
        wr(8'hA3);
        fork
            begin
                repeat (3) @(negedge clk);
                div = 16'd4;
                wr(8'h0F);
            end
            begin
                @(negedge clk);
                check_frame(8'hA3, 1);
                check_frame(8'h0F, 4);
            end
        join
        check("dc_busy_end", busy, 0);
        check("dc_empty_end", empty, 1);

        // Fill and overflow
        div = 16'd9;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    wr_en   = 1'b1;
                    wr_data = k[7:0];
                    @(negedge clk);
                    if (k == 8) begin
                        check("fill_count", count, 8);
                        check("fill_full", full, 1);
                        check("fill_ovf0", overflow, 0);
                    end
                    if (k == 9) begin
                        check("drop_ovf", overflow, 1);
                        check("drop_count", count, 8);
                    end
                end
                wr_en = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int k = 0; k < 9; k++) check_frame(k[7:0], 9);
            end
        join
        check("fill_busy_end", busy, 0);
        check("fill_empty_end", empty, 1);
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);

        // Pop/push race at the STOP->START boundary with count=DEPTH-1
        div = 16'd1;
        wr(8'h10);
        for (int k = 1; k < 8; k++) wr(k[7:0]);
        check("race_pre_count", count, FIFO_DEPTH - 1);
        repeat (13) @(negedge clk);
        wr(8'h77);
        check("race_count", count, FIFO_DEPTH - 1);
        check("race_ovf", overflow, 0);
        check("race_full", full, 0);
        check("race_tx_start", tx, 0);
        repeat (8 * 20 + 10) @(negedge clk);
        check("race_drain_empty", empty, 1);
        check("race_drain_busy", busy, 0);

        // Reset mid-frame
        div = 16'd3;
        wr(8'hFF);
        for (int k = 0; k < 4; k++) wr(8'hC0 + k[7:0]);
        repeat (10) @(negedge clk);
        check("mr_count_pre", count, 4);
        check("mr_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("mr_tx", tx, 1);
        check("mr_count", count, 0);
        check("mr_busy", busy, 0);
        check("mr_empty", empty, 1);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mr_no_resume", bad, 0);

        // Reset during a start bit forces tx high without a clock edge
        div = 16'd3;
        wr(8'h00);
        @(negedge clk);
        check("ar_tx_low", tx, 0);
        reset = 1'b1;
        #1;
        check("ar_tx_high", tx, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
